src_pkt_mux: RTL

SRC_PKT_MUX -- requirements
Module: src_pkt_mux

---
 rtl/src_pkt_mux_pkg.sv | 17 +
 rtl/src_pkt_mux_rr_pick.sv | 31 +++
 rtl/src_pkt_mux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/src_pkt_mux_pkg.sv
// Shared types and constants for the packet mux: FSM states and header layout.
package src_pkt_mux_pkg;

    localparam int HDR_WORDS   = 2;
    localparam int HDR_IDX_CH  = 0;
    localparam int HDR_IDX_SEQ = 1;
    localparam int SEQ_W       = 8;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD
    } state_e;

endpackage

// File: rtl/src_pkt_mux_rr_pick.sv
// Combinational circular arbiter: first requester after 'last', wrapping around.
module rr_pick
    import src_pkt_mux_pkg::*;
#(
    parameter int CH_NUM = 4
) (
    input  logic [CH_NUM-1:0]         req,
    input  logic [$clog2(CH_NUM)-1:0] last,
    output logic [$clog2(CH_NUM)-1:0] grant_idx,
    output logic                      grant_vld
);

    localparam int CW = $clog2(CH_NUM);

    always_comb begin : search
        logic [CW:0] idx;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        // Scan farthest-first so the nearest requester after 'last' wins.
        for (int k = CH_NUM; k >= 1; k--) begin
            idx = {1'b0, last} + (CW+1)'(k);
            if (idx >= (CW+1)'(CH_NUM)) idx = idx - (CW+1)'(CH_NUM);
            if (req[idx[CW-1:0]]) begin
                grant_idx = idx[CW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/src_pkt_mux.sv
// Multiplexes CH_NUM byte streams into framed packets: [ch][seq][PKT_LEN payload words].
module src_pkt_mux
    import src_pkt_mux_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 1024
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       mode,
    input  logic                       sel_step,
    input  logic [CH_NUM-1:0]          s_valid,
    input  logic [CH_NUM*DATA_W-1:0]   s_data,
    output logic [CH_NUM-1:0]          s_ready,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_sop,
    output logic                       m_eop,
    input  logic                       m_ready,
    output logic [$clog2(CH_NUM)-1:0]  cur_ch
);

    localparam int CW = $clog2(CH_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);
    localparam logic [CW-1:0]    CH_MAX    = CW'(CH_NUM - 1);

    state_e                        state_q;
    logic [CW-1:0]                 ch_q;
    logic [CW-1:0]                 sel_ch_q;
    logic [CW-1:0]                 last_ch_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [CH_NUM-1:0][SEQ_W-1:0]  seq_q;

    logic [CW-1:0]     grant_idx;
    logic              grant_vld;
    logic              ch_vld;
    logic [DATA_W-1:0] ch_data;
    logic              last_beat;
    logic              xfer;

    rr_pick #(.CH_NUM(CH_NUM)) u_rr_pick (
        .req       (s_valid),
        .last      (last_ch_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign ch_vld    = s_valid[ch_q];
    assign ch_data   = s_data[int'(ch_q)*DATA_W +: DATA_W];
    assign last_beat = (cnt_q == LAST_BEAT);
    assign xfer      = m_valid & m_ready;
    assign cur_ch    = ch_q;

    // Headers come from registered state; payload is a zero-latency pass-through.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        s_ready = '0;
        case (state_q)
            ST_HDR0: begin
                m_valid = 1'b1;
                m_sop   = 1'b1;
                m_data  = DATA_W'(ch_q);
            end
            ST_HDR1: begin
                m_valid = 1'b1;
                m_data  = DATA_W'(seq_q[ch_q]);
            end
            ST_PAYLOAD: begin
                m_valid       = ch_vld;
                m_data        = ch_data;
                m_eop         = last_beat;
                s_ready[ch_q] = m_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            sel_ch_q  <= '0;
            last_ch_q <= CH_MAX;
            cnt_q     <= '0;
            seq_q     <= '0;
        end else begin
            if (sel_step) sel_ch_q <= (sel_ch_q == CH_MAX) ? '0 : sel_ch_q + CW'(1);
            case (state_q)
                ST_IDLE: begin
                    if (!mode && s_valid[sel_ch_q]) begin
                        ch_q    <= sel_ch_q;
                        state_q <= ST_HDR0;
                    end else if (mode && grant_vld) begin
                        ch_q    <= grant_idx;
                        state_q <= ST_HDR0;
                    end
                end
                ST_HDR0: if (m_ready) state_q <= ST_HDR1;
                ST_HDR1: if (m_ready) state_q <= ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (xfer) begin
                        if (last_beat) begin
                            cnt_q       <= '0;
                            seq_q[ch_q] <= seq_q[ch_q] + SEQ_W'(1);
                            last_ch_q   <= ch_q;
                            state_q     <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
